// File: rtl/sha2_msg_schedule.sv
// SHA-2 message-schedule expander: loads one 16-word block and streams W[0..NumRounds-1].
module sha2_msg_schedule #(
  parameter int unsigned Width = 32,
  localparam int unsigned NumRounds = (Width == 64) ? 80 : 64,
  localparam int unsigned IdxW = $clog2(NumRounds)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                blk_valid_i,
  output logic                blk_ready_o,
  input  logic [16*Width-1:0] blk_i,
  output logic                w_valid_o,
  input  logic                w_ready_i,
  output logic [Width-1:0]    w_o,
  output logic [IdxW-1:0]     w_idx_o,
  output logic                w_last_o
);

  // Only SHA-256 and SHA-512 word sizes are meaningful.
  if (Width != 32 && Width != 64) begin : g_bad_width
    $error("sha2_msg_schedule: Width must be 32 or 64");
  end

  localparam int unsigned S0R1 = (Width == 64) ? 1  : 7;
  localparam int unsigned S0R2 = (Width == 64) ? 8  : 18;
  localparam int unsigned S0SH = (Width == 64) ? 7  : 3;
  localparam int unsigned S1R1 = (Width == 64) ? 19 : 17;
  localparam int unsigned S1R2 = (Width == 64) ? 61 : 19;
  localparam int unsigned S1SH = (Width == 64) ? 6  : 10;

  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumRounds - 1);
  localparam logic [IdxW-1:0] PenultIdx = IdxW'(NumRounds - 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic             load, adv;
  logic [Width-1:0] window_q [16];
  logic [Width-1:0] next_w;
  logic [IdxW-1:0]  t_q;
  logic             last_q;

  function automatic logic [Width-1:0] rotr(input logic [Width-1:0] x, input int unsigned n);
    return (x >> n) | (x << (Width - n));
  endfunction

  function automatic logic [Width-1:0] sig0(input logic [Width-1:0] x);
    return rotr(x, S0R1) ^ rotr(x, S0R2) ^ (x >> S0SH);
  endfunction

  function automatic logic [Width-1:0] sig1(input logic [Width-1:0] x);
    return rotr(x, S1R1) ^ rotr(x, S1R2) ^ (x >> S1SH);
  endfunction

  // Next schedule word from the sliding window; words past the last useful one are simply dropped.
  assign next_w = sig1(window_q[14]) + window_q[9] + sig0(window_q[1]) + window_q[0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and control decode; flush overrides any handshake.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    adv     = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (blk_valid_i) begin
            load    = 1'b1;
            state_d = RUN;
          end
        end
        RUN: begin
          if (w_ready_i) begin
            adv = 1'b1;
            if (t_q == LastIdx) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Window, round index and last flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 16; i++) window_q[i] <= '0;
      t_q    <= '0;
      last_q <= 1'b0;
    end else if (flush_i) begin
      t_q    <= '0;
      last_q <= 1'b0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) window_q[i] <= blk_i[(15-i)*Width +: Width];
      t_q    <= '0;
      last_q <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < 15; i++) window_q[i] <= window_q[i+1];
      window_q[15] <= next_w;
      t_q    <= (t_q == LastIdx) ? '0 : t_q + IdxW'(1);
      last_q <= (t_q == PenultIdx);
    end
  end

  // Handshake flags are pure decodes of the state register.
  assign blk_ready_o = (state_q == IDLE);
  assign w_valid_o   = (state_q == RUN);
  assign w_o         = window_q[0];
  assign w_idx_o     = t_q;
  assign w_last_o    = last_q;

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Self-checking bench for sha2_msg_schedule at both word widths.
module tb_sha2_msg_schedule;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush32, blk_valid32, w_ready32;
  logic [511:0] blk32;
  logic         blk_ready32, w_valid32, w_last32;
  logic [31:0]  w32;
  logic [5:0]   idx32;
  logic         flush64, blk_valid64, w_ready64;
  logic [1023:0] blk64;
  logic         blk_ready64, w_valid64, w_last64;
  logic [63:0]  w64;
  logic [6:0]   idx64;

  int n_assert = 0;
  int n_fail = 0;

  logic [63:0] exp_w [80];
  logic [63:0] got_w [80];

  always #5 clk = ~clk;

  sha2_msg_schedule #(.Width(32)) u_dut32 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush32),
    .blk_valid_i(blk_valid32), .blk_ready_o(blk_ready32), .blk_i(blk32),
    .w_valid_o(w_valid32), .w_ready_i(w_ready32), .w_o(w32),
    .w_idx_o(idx32), .w_last_o(w_last32)
  );

  sha2_msg_schedule #(.Width(64)) u_dut64 (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush64),
    .blk_valid_i(blk_valid64), .blk_ready_o(blk_ready64), .blk_i(blk64),
    .w_valid_o(w_valid64), .w_ready_i(w_ready64), .w_o(w64),
    .w_idx_o(idx64), .w_last_o(w_last64)
  );

  // Reference sigma functions straight from the SHA-2 definitions.
  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] s0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] s0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] s1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction

  // Full expanded schedule W[t] computed from the recurrence over the whole array.
  task automatic build_model(input bit wide, input logic [1023:0] b);
    logic [31:0] v;
    int n;
    n = wide ? 80 : 64;
    for (int t = 0; t < n; t++) begin
      if (t < 16) begin
        if (wide) exp_w[t] = b[(15-t)*64 +: 64];
        else      exp_w[t] = {32'h0, b[(15-t)*32 +: 32]};
      end else if (wide) begin
        exp_w[t] = s1_64(exp_w[t-2]) + exp_w[t-7] + s0_64(exp_w[t-15]) + exp_w[t-16];
      end else begin
        v = s1_32(exp_w[t-2][31:0]) + exp_w[t-7][31:0] + s0_32(exp_w[t-15][31:0]) + exp_w[t-16][31:0];
        exp_w[t] = {32'h0, v};
      end
    end
  endtask

  function automatic logic [1023:0] rand_block();
    logic [1023:0] b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom;
    return b;
  endfunction

  // Offer a block (called at a negedge); returns at the negedge after acceptance.
  task automatic offer(input bit wide, input logic [1023:0] b);
    int n;
    logic ov, obr;
    logic [6:0] oi;
    n = 0;
    if (wide) begin blk64 = b; blk_valid64 = 1'b1; end
    else begin blk32 = b[511:0]; blk_valid32 = 1'b1; end
    obr = wide ? blk_ready64 : blk_ready32;
    while (!obr && n < 200) begin
      @(negedge clk);
      n++;
      obr = wide ? blk_ready64 : blk_ready32;
    end
    @(negedge clk);
    if (wide) blk_valid64 = 1'b0; else blk_valid32 = 1'b0;
    ov = wide ? w_valid64 : w_valid32;
    oi = wide ? idx64 : {1'b0, idx32};
    n_assert++;
    if (ov !== 1'b1 || oi !== 7'd0) begin
      n_fail++;
      $display("FAIL first_word_latency: valid=%b idx=%0d, expected valid=1 idx=0", ov, oi);
    end
  endtask

  // Consume words k < stop from the current negedge, ready asserted with ready_pct percent.
  task automatic collect(input bit wide, input int n, input int stop, input int ready_pct);
    int k, cyc;
    bit stalled, r;
    logic ov, ol, obr, pl;
    logic [63:0] ow, pw;
    logic [6:0] oi, pi;
    k = 0; cyc = 0; stalled = 0; pw = '0; pi = '0; pl = 1'b0;
    while (k < stop && cyc < 3000) begin
      ov  = wide ? w_valid64 : w_valid32;
      ow  = wide ? w64 : {32'h0, w32};
      oi  = wide ? idx64 : {1'b0, idx32};
      ol  = wide ? w_last64 : w_last32;
      obr = wide ? blk_ready64 : blk_ready32;
      n_assert++;
      if (ov !== 1'b1 || obr !== 1'b0) begin
        n_fail++;
        $display("FAIL run_flags: w_valid=%b blk_ready=%b at word %0d, expected 1/0", ov, obr, k);
      end
      if (stalled) begin
        n_assert++;
        if (ow !== pw || oi !== pi || ol !== pl) begin
          n_fail++;
          $display("FAIL stall_hold: w=%h idx=%0d last=%b, expected held w=%h idx=%0d last=%b",
                   ow, oi, ol, pw, pi, pl);
        end
      end
      r = ($urandom_range(0, 99) < ready_pct);
      if (wide) w_ready64 = r; else w_ready32 = r;
      if (r) begin
        got_w[k] = ow;
        n_assert++;
        if (ow !== exp_w[k] || oi !== 7'(k) || ol !== (k == n - 1)) begin
          n_fail++;
          $display("FAIL word: got w=%h idx=%0d last=%b, expected w=%h idx=%0d last=%b",
                   ow, oi, ol, exp_w[k], k, (k == n - 1));
        end
        k++;
        stalled = 0;
      end else begin
        stalled = 1; pw = ow; pi = oi; pl = ol;
      end
      @(negedge clk);
      cyc++;
    end
    if (wide) w_ready64 = 1'b0; else w_ready32 = 1'b0;
    n_assert++;
    if (k < stop) begin
      n_fail++;
      $display("FAIL collect_timeout: got %0d words, expected %0d", k, stop);
    end
    if (stop == n) begin
      ov  = wide ? w_valid64 : w_valid32;
      obr = wide ? blk_ready64 : blk_ready32;
      n_assert++;
      if (ov !== 1'b0 || obr !== 1'b1) begin
        n_fail++;
        $display("FAIL idle_after_last: w_valid=%b blk_ready=%b, expected 0/1", ov, obr);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_assert++;
    if (blk_ready32 !== 1'b1 || w_valid32 !== 1'b0 || w32 !== 32'h0 || idx32 !== 6'd0 || w_last32 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset32: ready=%b valid=%b w=%h idx=%0d last=%b, expected 1 0 0 0 0",
               blk_ready32, w_valid32, w32, idx32, w_last32);
    end
    n_assert++;
    if (blk_ready64 !== 1'b1 || w_valid64 !== 1'b0 || w64 !== 64'h0 || idx64 !== 7'd0 || w_last64 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset64: ready=%b valid=%b w=%h idx=%0d last=%b, expected 1 0 0 0 0",
               blk_ready64, w_valid64, w64, idx64, w_last64);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if (blk_ready32 !== 1'b1 || w_valid32 !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: ready=%b valid=%b, expected 1/0", blk_ready32, w_valid32);
    end
  endtask

  function automatic logic [1023:0] abc_block();
    logic [511:0] b;
    b = {32'h61626380, {14{32'h0}}, 32'h00000018};
    return {512'h0, b};
  endfunction

  task automatic test_abc();
    build_model(0, abc_block());
    offer(0, abc_block());
    collect(0, 64, 64, 100);
    n_assert++;
    if (got_w[15] !== 64'h18 || got_w[16] !== 64'h61626380 || got_w[17] !== 64'h000F0000) begin
      n_fail++;
      $display("FAIL abc_golden: W15=%h W16=%h W17=%h, expected 18 61626380 000f0000",
               got_w[15], got_w[16], got_w[17]);
    end
  endtask

  task automatic test_backpressure();
    build_model(0, abc_block());
    offer(0, abc_block());
    collect(0, 64, 64, 50);
  endtask

  task automatic test_back_to_back();
    logic [1023:0] a, b;
    a = rand_block();
    b = abc_block();
    build_model(0, a);
    offer(0, a);
    blk32 = b[511:0];
    blk_valid32 = 1'b1;
    collect(0, 64, 64, 70);
    build_model(0, b);
    @(negedge clk);
    blk_valid32 = 1'b0;
    n_assert++;
    if (w_valid32 !== 1'b1 || idx32 !== 6'd0 || w32 !== exp_w[0][31:0]) begin
      n_fail++;
      $display("FAIL b2b_accept: valid=%b idx=%0d w=%h, expected 1 0 %h", w_valid32, idx32, w32, exp_w[0][31:0]);
    end
    collect(0, 64, 64, 100);
  endtask

  task automatic test_flush();
    logic [1023:0] b;
    b = rand_block();
    build_model(0, abc_block());
    offer(0, abc_block());
    collect(0, 64, 20, 100);
    flush32 = 1'b1;
    w_ready32 = 1'b1;
    blk32 = b[511:0];
    blk_valid32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    w_ready32 = 1'b0;
    n_assert++;
    if (w_valid32 !== 1'b0 || blk_ready32 !== 1'b1 || idx32 !== 6'd0) begin
      n_fail++;
      $display("FAIL flush_idle: valid=%b ready=%b idx=%0d, expected 0 1 0", w_valid32, blk_ready32, idx32);
    end
    build_model(0, b);
    @(negedge clk);
    blk_valid32 = 1'b0;
    n_assert++;
    if (w_valid32 !== 1'b1 || idx32 !== 6'd0 || w32 !== exp_w[0][31:0]) begin
      n_fail++;
      $display("FAIL flush_restart: valid=%b idx=%0d w=%h, expected 1 0 %h", w_valid32, idx32, w32, exp_w[0][31:0]);
    end
    collect(0, 64, 64, 100);
  endtask

  task automatic test_midstream_reset();
    build_model(0, abc_block());
    offer(0, abc_block());
    collect(0, 64, 40, 100);
    #2;
    rst_n = 1'b0;
    #1;
    n_assert++;
    if (w_valid32 !== 1'b0 || w32 !== 32'h0 || blk_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: valid=%b w=%h ready=%b, expected 0 0 1", w_valid32, w32, blk_ready32);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_assert++;
    if (w_valid32 !== 1'b0 || blk_ready32 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b ready=%b, expected 0 1", w_valid32, blk_ready32);
    end
  endtask

  task automatic test_all_ones();
    build_model(0, '1);
    offer(0, '1);
    collect(0, 64, 64, 100);
    build_model(1, '1);
    offer(1, '1);
    collect(1, 80, 80, 100);
  endtask

  task automatic test_random();
    logic [1023:0] b;
    for (int i = 0; i < 3; i++) begin
      b = rand_block();
      build_model(0, b);
      offer(0, b);
      collect(0, 64, 64, 60);
      b = rand_block();
      build_model(1, b);
      offer(1, b);
      collect(1, 80, 80, 60);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush32 = 1'b0; blk_valid32 = 1'b0; w_ready32 = 1'b0; blk32 = '0;
    flush64 = 1'b0; blk_valid64 = 1'b0; w_ready64 = 1'b0; blk64 = '0;
    repeat (2) @(negedge clk);
    test_reset();
    test_abc();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_midstream_reset();
    test_all_ones();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
